// File: rtl/array_serializer_pkg.sv
// Shared widths, frame type, output FSM states and the frame-sum helper
// used by the array serializer and its frame FIFO.
package serializer_pkg;

    localparam int ELEM_W      = 8;
    localparam int N_ELEM      = 4;
    localparam int FRAME_DEPTH = 2;
    localparam int SUM_W       = 10;

    localparam int IDX_W = $clog2(N_ELEM);
    localparam int PTR_W = $clog2(FRAME_DEPTH);
    localparam int CNT_W = $clog2(FRAME_DEPTH + 1);

    // Element i of a frame lives at frame[i].
    typedef logic [N_ELEM-1:0][ELEM_W-1:0] frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Each element is zero-extended before accumulating, so 4 x 0xFF gives 0x3FC.
    function automatic logic [SUM_W-1:0] frame_sum_of(input frame_t f);
        logic [SUM_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            acc = acc + SUM_W'(f[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/array_serializer_if.sv
// Frame-in / element-out bundle between the upstream array stage, the
// serializer and the downstream consumer.
interface array_serializer_if;
    import serializer_pkg::*;

    logic [ELEM_W-1:0] in_array [0:N_ELEM-1];
    logic              in_valid;
    logic              in_ready;
    logic [ELEM_W-1:0] out_data;
    logic [IDX_W-1:0]  out_index;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  frame_sum;
    logic              overflow;

    modport slave (
        input  in_array, in_valid, out_ready,
        output in_ready, out_data, out_index, out_last, out_valid, frame_sum, overflow
    );

    modport master (
        output in_array, in_valid, out_ready,
        input  in_ready, out_data, out_index, out_last, out_valid, frame_sum, overflow
    );

endinterface

// File: rtl/array_serializer_frame_fifo.sv
// Two-entry frame FIFO holding whole frames plus their precomputed sums.
// The head frame is read combinationally so a freshly pushed frame is visible next cycle.
module frame_fifo
    import serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  frame_t           i_frame,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output frame_t           o_head,
    output logic [SUM_W-1:0] o_head_sum
);

    frame_t           r_mem     [FRAME_DEPTH];
    logic [SUM_W-1:0] r_sum_mem [FRAME_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_wr_en;
    logic             w_rd_en;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] w_count_next;

    assign o_full  = (r_count == CNT_W'(FRAME_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

    // Guards keep the FIFO consistent even if a caller ignores full/empty.
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(FRAME_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(FRAME_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= w_wr_ptr_next;
            if (w_rd_en) r_rd_ptr <= w_rd_ptr_next;
            r_count <= w_count_next;
        end
    end

    // Storage carries no reset; validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem[r_wr_ptr]     <= i_frame;
            r_sum_mem[r_wr_ptr] <= frame_sum_of(i_frame);
        end
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_head_sum = r_sum_mem[r_rd_ptr];

endmodule

// File: rtl/array_serializer.sv
// Serializes buffered four-element frames into one element per beat with
// valid/ready flow control, frame sum side-band and a sticky drop flag.
module array_serializer
    import serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    array_serializer_if.slave  bus
);

    state_e           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_overflow;

    frame_t           w_in_frame;
    frame_t           w_head;
    logic [SUM_W-1:0] w_head_sum;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_drop;
    logic             w_valid;
    logic             w_beat;
    logic             w_pop;
    logic             w_nonempty_next;

    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_unpack
        assign w_in_frame[gi] = bus.in_array[gi];
    end

    frame_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_frame    (w_in_frame),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count),
        .o_head     (w_head),
        .o_head_sum (w_head_sum)
    );

    // A frame offered while full is dropped even if a pop frees a slot this cycle.
    assign w_push  = bus.in_valid && !w_full;
    assign w_drop  = bus.in_valid && w_full;
    assign w_valid = (r_state == SEND);
    assign w_beat  = w_valid && bus.out_ready;
    assign w_pop   = w_beat && (r_idx == IDX_W'(N_ELEM - 1));

    // Looking at next-cycle occupancy lets a push into an empty buffer show element 0 right away.
    assign w_nonempty_next = w_push || (!w_empty && !(w_pop && w_count == CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_nonempty_next) r_state <= SEND;
                end
                SEND: begin
                    if (!w_nonempty_next) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_pop)       r_idx <= '0;
            else if (w_beat) r_idx <= r_idx + IDX_W'(1);

            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? w_head[r_idx] : '0;
    assign bus.out_index = w_valid ? r_idx : '0;
    assign bus.out_last  = w_valid && (r_idx == IDX_W'(N_ELEM - 1));
    assign bus.frame_sum = w_valid ? w_head_sum : '0;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_array_serializer.sv
// Randomized and directed bench for array_serializer against a queue-of-frames
// reference model that is stepped once per clock edge.
module tb_array_serializer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    array_serializer_if ifc ();

    array_serializer dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    // Model: pending frames (byte i at [8*i +: 8]), position within head, sticky drop flag.
    logic [31:0] m_q[$];
    int          m_pos;
    bit          m_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit          v;
        logic [31:0] f;
        int          sum;
        v   = (m_q.size() > 0);
        f   = v ? m_q[0] : 32'h0;
        sum = v ? (int'(f[7:0]) + int'(f[15:8]) + int'(f[23:16]) + int'(f[31:24])) : 0;
        check("out_valid", 32'(ifc.out_valid), 32'(v));
        check("out_data",  32'(ifc.out_data),  v ? 32'(f[8*m_pos +: 8]) : 32'h0);
        check("out_index", 32'(ifc.out_index), v ? 32'(m_pos) : 32'h0);
        check("out_last",  32'(ifc.out_last),  32'(v && m_pos == 3));
        check("frame_sum", 32'(ifc.frame_sum), 32'(sum));
        check("in_ready",  32'(ifc.in_ready),  32'(m_q.size() < 2));
        check("overflow",  32'(ifc.overflow),  32'(m_ovf));
    endtask

    // Apply the effect of the upcoming rising edge given the currently driven inputs.
    task automatic model_step();
        bit acc;
        bit room;
        if (rst) begin
            m_q.delete();
            m_pos = 0;
            m_ovf = 1'b0;
        end else begin
            acc  = (m_q.size() > 0) && ifc.out_ready;
            room = (m_q.size() < 2);
            if (ifc.in_valid && !room) m_ovf = 1'b1;
            if (acc) begin
                m_pos++;
                if (m_pos == 4) begin
                    void'(m_q.pop_front());
                    m_pos = 0;
                end
            end
            if (ifc.in_valid && room)
                m_q.push_back({ifc.in_array[3], ifc.in_array[2], ifc.in_array[1], ifc.in_array[0]});
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        $display("[TB] t=%0t rst=%0b iv=%0b ir=%0b ov=%0b or=%0b data=%02h idx=%0d last=%0b sum=%03h ovf=%0b",
                 $time, rst, ifc.in_valid, ifc.in_ready, ifc.out_valid, ifc.out_ready,
                 ifc.out_data, ifc.out_index, ifc.out_last, ifc.frame_sum, ifc.overflow);
        check_outputs();
    endtask

    task automatic set_frame(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        ifc.in_array[0] = b0;
        ifc.in_array[1] = b1;
        ifc.in_array[2] = b2;
        ifc.in_array[3] = b3;
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        set_frame(b0, b1, b2, b3);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        set_frame(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        run(2);
        check("reset_in_ready", 32'(ifc.in_ready), 32'h1);
        rst = 1'b0;
        run(1);

        // Single frame, downstream always ready.
        ifc.out_ready = 1'b1;
        push_frame(8'h0B, 8'h0C, 8'h0D, 8'h0E);
        check("single_sum", 32'(ifc.frame_sum), 32'h032);
        run(5);

        // Backpressure on the first beat.
        ifc.out_ready = 1'b0;
        push_frame(8'h0A, 8'h14, 8'h05, 8'h0A);
        run(2);
        check("bp_data_held", 32'(ifc.out_data), 32'h0A);
        ifc.out_ready = 1'b1;
        run(5);

        // Back-to-back frames.
        push_frame(8'h01, 8'h02, 8'h03, 8'h04);
        push_frame(8'h10, 8'h20, 8'h30, 8'h40);
        run(9);

        // Overflow: third push while full is dropped.
        ifc.out_ready = 1'b0;
        push_frame(8'h11, 8'h22, 8'h33, 8'h44);
        push_frame(8'h55, 8'h66, 8'h77, 8'h88);
        check("ovf_in_ready_low", 32'(ifc.in_ready), 32'h0);
        push_frame(8'h99, 8'hAA, 8'hBB, 8'hCC);
        check("ovf_set", 32'(ifc.overflow), 32'h1);
        run(3);
        ifc.out_ready = 1'b1;
        run(10);
        check("ovf_sticky", 32'(ifc.overflow), 32'h1);

        // Maximum sum.
        push_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check("max_sum", 32'(ifc.frame_sum), 32'h3FC);
        run(5);

        // Reset in the middle of a two-frame backlog, with a coincident push.
        ifc.out_ready = 1'b0;
        push_frame(8'h21, 8'h22, 8'h23, 8'h24);
        push_frame(8'h31, 8'h32, 8'h33, 8'h34);
        ifc.out_ready = 1'b1;
        run(2);
        rst = 1'b1;
        set_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        rst = 1'b0;
        check("rst_out_valid", 32'(ifc.out_valid), 32'h0);
        check("rst_overflow",  32'(ifc.overflow),  32'h0);
        check("rst_in_ready",  32'(ifc.in_ready),  32'h1);
        push_frame(8'h05, 8'h0A, 8'h14, 8'h28);
        check("post_rst_idx",  32'(ifc.out_index), 32'h0);
        check("post_rst_data", 32'(ifc.out_data),  32'h05);
        run(5);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            ifc.in_valid  = ($urandom_range(0, 99) < 40);
            ifc.out_ready = ($urandom_range(0, 99) < 70);
            set_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick();
        end
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
